wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 16-bit pipelined core. It consumes the MEM/WB pipeline bundle, selects the write-back value (ALU/FU result or memory load data) and commits it to an 8×16 register file. It serves the ID stage through two read ports with same-cycle write-through bypass, and exports the committed write for EX-stage forwarding.

## Interface
- DATA_W, 16, datapath width
- ADDR_W, 3, register address width (2^ADDR_W registers)
- CNT_W, 16, retire counter width
- clk_i  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- wb_i  in  2  MEM/WB control: bit1 MemtoReg, bit0 regWrite
- fu_result_i  in  DATA_W  FU/ALU result from MEM/WB
- mem_read_data_i  in  DATA_W  load data from MEM/WB
- rd_addr_i  in  ADDR_W  destination register from MEM/WB
- rs_addr_i  in  ADDR_W  ID read port A address
- rt_addr_i  in  ADDR_W  ID read port B address
- rs_data_o  out  DATA_W  read port A data
- rt_data_o  out  DATA_W  read port B data
- fwd_en_o  out  1  effective write enable this cycle, for the forwarding unit
- fwd_addr_o  out  ADDR_W  write address this cycle
- fwd_data_o  out  DATA_W  write data this cycle
- retire_cnt_o  out  CNT_W  count of committed register writes

## Operation
- Write data: wdata = wb_i[1] ? mem_read_data_i : fu_result_i.
- Effective write enable: we = wb_i[0] && (rd_addr_i != 0). Register r0 is hardwired to 0; writes to r0 are discarded and are not counted.
- On posedge clk_i with we=1: regs[rd_addr_i] <= wdata; retire_cnt <= retire_cnt + 1.
- retire_cnt saturates at 2^CNT_W−1 and does not wrap.
- Read port A: if rs_addr_i==0, output 0. Else if we && rs_addr_i==rd_addr_i, output wdata (bypass). Else output regs[rs_addr_i]. Port B is identical using rt_addr_i.
- When both ports address the register being written, both return wdata.
- fwd_en_o=we, fwd_addr_o=rd_addr_i, fwd_data_o=wdata. These outputs are driven combinationally regardless of we; the consumer qualifies them with fwd_en_o.
- wb_i[1] with wb_i[0]=0 is a no-op. The mux still drives fwd_data_o, but there is no write.

## Timing
- Reset (rst_n=0, asynchronous): all registers are 0 and retire_cnt_o=0 immediately. Read ports therefore return 0 unless bypassing. fwd_* follow the inputs, which are 0 out of a reset MEM/WB register.
- Reset asserted mid-operation clears the register file within the same cycle. A write on the posedge that coincides with rst_n=0 is lost.
- Deassertion of rst_n takes effect at the first posedge with rst_n=1.
- Write latency: one edge. Data is visible via regs from the cycle after the edge and via bypass in the same cycle.
- Read latency: zero (combinational from address, regs and the bypass path).
- No stall input: the block commits every cycle in which we=1. Bubbles arrive as wb_i=0.

## Structure
- Shared package cpu16_pkg:
  - DATA_W and ADDR_W constants.
  - WB_MEMTOREG=1 and WB_REGWRITE=0 bit indices.
  - typedef for the 2-bit WB control bundle.
- One sub-module, regfile_core: storage array, one write port, two asynchronous read ports with r0=0, async reset.
- The write-data mux, bypass compare, forwarding outputs and retire counter live in wb_regfile.

## Test plan
- Reset then read: assert rst_n=0 mid-run after r3=0x1234 → rs_data_o(r3)=0 immediately; retire_cnt_o=0.
- ALU write: wb_i=01, rd=5, fu=0xBEEF, mem=0x1111 → after the edge, rs_data_o(r5)=0xBEEF; retire_cnt increments by 1.
- Load write: wb_i=11, rd=2, mem=0x00A5 → after the edge, rt_data_o(r2)=0x00A5; fwd_data_o=0x00A5 during that cycle.
- Bypass: r4 holds 0x0001; same cycle wb_i=01, rd=4, fu=0x7777, rs=rt=4 → rs_data_o=rt_data_o=0x7777 before the edge.
- r0 protection: wb_i=01, rd=0, fu=0xFFFF → fwd_en_o=0, rs_data_o(r0)=0, retire_cnt unchanged.
- Counter saturation (CNT_W=4): 20 consecutive writes to r1 → retire_cnt_o=15 and holds at 15.

Source files
------------

// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared datapath constants and the MEM/WB write-back control
// bundle for the 16-bit pipelined core.
//   DATA_W       datapath width
//   ADDR_W       register address width (2**ADDR_W architectural registers)
//   WB_MEMTOREG  wb bundle bit selecting load data over the FU result
//   WB_REGWRITE  wb bundle bit requesting a register write
package cpu16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  // MEM/WB write-back control: bit1 MemtoReg, bit0 regWrite
  typedef logic [1:0] wb_ctrl_t;

  // Register-write request decode shared by the write-back stage.
  function automatic logic wb_wants_write(input wb_ctrl_t wb);
    return wb[WB_REGWRITE];
  endfunction

  function automatic logic wb_selects_mem(input wb_ctrl_t wb);
    return wb[WB_MEMTOREG];
  endfunction

endpackage

// File: rtl/regfile_core.sv
// regfile_core: architectural register storage, one synchronous write port,
// two asynchronous read ports. Register 0 reads as zero and ignores writes.
//   clk_i      clock, writes on posedge
//   rst_n      asynchronous active-low reset, clears every register
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddr_a_i  read port A address   -> rdata_a_o
//   raddr_b_i  read port B address   -> rdata_b_o
module regfile_core
  import cpu16_pkg::*;
#(
  parameter int DATA_W = cpu16_pkg::DATA_W,
  parameter int ADDR_W = cpu16_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on the read side as well, so it stays constant
  // even if the write gate above is ever relaxed.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0) rdata_a_o = regs[raddr_a_i];
    if (raddr_b_i != '0) rdata_b_o = regs[raddr_b_i];
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus architectural register file.
// Selects the write-back value from the MEM/WB bundle, commits it to the
// register file, serves two ID read ports with same-cycle write-through
// bypass, and exports the committed write for EX-stage forwarding.
//   clk_i, rst_n         clock / asynchronous active-low reset
//   wb_i                 MEM/WB control (bit1 MemtoReg, bit0 regWrite)
//   fu_result_i          FU/ALU result
//   mem_read_data_i      load data
//   rd_addr_i            destination register
//   rs_addr_i/rt_addr_i  read port addresses -> rs_data_o/rt_data_o
//   fwd_en_o/addr/data   effective write of this cycle for forwarding
//   retire_cnt_o         saturating count of committed register writes
module wb_regfile
  import cpu16_pkg::*;
#(
  parameter int DATA_W = cpu16_pkg::DATA_W,
  parameter int ADDR_W = cpu16_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [1:0]        wb_i,
  input  logic [DATA_W-1:0] fu_result_i,
  input  logic [DATA_W-1:0] mem_read_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              fwd_en_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  wb_ctrl_t          wb_ctrl;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] core_rs_data;
  logic [DATA_W-1:0] core_rt_data;
  logic [CNT_W-1:0]  retire_cnt;

  assign wb_ctrl = wb_i;

  // Write-back mux and effective enable; r0 writes are dropped here so they
  // neither reach storage nor bump the retire counter.
  always_comb begin
    wdata = wb_selects_mem(wb_ctrl) ? mem_read_data_i : fu_result_i;
    we    = wb_wants_write(wb_ctrl) && (rd_addr_i != '0);
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .we_i      (we),
    .waddr_i   (rd_addr_i),
    .wdata_i   (wdata),
    .raddr_a_i (rs_addr_i),
    .raddr_b_i (rt_addr_i),
    .rdata_a_o (core_rs_data),
    .rdata_b_o (core_rt_data)
  );

  // Write-through bypass: a read of the register being written this cycle
  // sees the new value before the edge. r0 never bypasses because we=0
  // whenever rd_addr_i is zero.
  always_comb begin
    rs_data_o = core_rs_data;
    rt_data_o = core_rt_data;
    if (we && (rs_addr_i == rd_addr_i)) rs_data_o = wdata;
    if (we && (rt_addr_i == rd_addr_i)) rt_data_o = wdata;
  end

  // Forwarding outputs follow the bundle unconditionally; consumers gate
  // on fwd_en_o.
  always_comb begin
    fwd_en_o   = we;
    fwd_addr_o = rd_addr_i;
    fwd_data_o = wdata;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (we && (retire_cnt != '1)) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int DW      = 16;
  localparam int AW      = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    wb_i = '0;
  logic [DW-1:0] fu_result_i = '0;
  logic [DW-1:0] mem_read_data_i = '0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [AW-1:0] rs_addr_i = '0;
  logic [AW-1:0] rt_addr_i = '0;
  logic [DW-1:0] rs_data_o;
  logic [DW-1:0] rt_data_o;
  logic          fwd_en_o;
  logic [AW-1:0] fwd_addr_o;
  logic [DW-1:0] fwd_data_o;
  logic [CW-1:0] retire_cnt_o;

  wb_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .wb_i            (wb_i),
    .fu_result_i     (fu_result_i),
    .mem_read_data_i (mem_read_data_i),
    .rd_addr_i       (rd_addr_i),
    .rs_addr_i       (rs_addr_i),
    .rt_addr_i       (rt_addr_i),
    .rs_data_o       (rs_data_o),
    .rt_data_o       (rt_data_o),
    .fwd_en_o        (fwd_en_o),
    .fwd_addr_o      (fwd_addr_o),
    .fwd_data_o      (fwd_data_o),
    .retire_cnt_o    (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // Architectural model: plain array of register values and an int counter.
  int m_regs [8];
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_wdata();
    return wb_i[1] ? int'(mem_read_data_i) : int'(fu_result_i);
  endfunction

  function automatic bit model_we();
    return wb_i[0] && (rd_addr_i != 0);
  endfunction

  function automatic int model_read(input int addr);
    if (addr == 0) return 0;
    if (model_we() && addr == int'(rd_addr_i)) return model_wdata();
    return m_regs[addr];
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_cnt = 0;
    end else if (model_we()) begin
      m_regs[rd_addr_i] = model_wdata();
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("rs_data", int'(rs_data_o), model_read(int'(rs_addr_i)));
      chk("rt_data", int'(rt_data_o), model_read(int'(rt_addr_i)));
      chk("fwd_en", int'(fwd_en_o), int'(model_we()));
      chk("fwd_addr", int'(fwd_addr_o), int'(rd_addr_i));
      chk("fwd_data", int'(fwd_data_o), model_wdata());
      chk("retire_cnt", int'(retire_cnt_o), m_cnt);
    end
  end

  task automatic drive(input logic [1:0] wb, input int rd, input int fu, input int mem,
                       input int rs, input int rt);
    wb_i            = wb;
    rd_addr_i       = AW'(rd);
    fu_result_i     = DW'(fu);
    mem_read_data_i = DW'(mem);
    rs_addr_i       = AW'(rs);
    rt_addr_i       = AW'(rt);
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    drive(2'b00, 0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("reset_cnt", int'(retire_cnt_o), 0);
    drive(2'b00, 0, 0, 0, 3, 7);
    chk("reset_rs", int'(rs_data_o), 0);
    chk("reset_rt", int'(rt_data_o), 0);

    // r3 = 0x1234, then reset mid-run
    drive(2'b01, 3, 'h1234, 'h0, 3, 0);
    chk("r3_bypass", int'(rs_data_o), 'h1234);
    step();
    drive(2'b00, 0, 0, 0, 3, 0);
    chk("r3_held", int'(rs_data_o), 'h1234);
    chk("cnt_after_r3", int'(retire_cnt_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rs", int'(rs_data_o), 0);
    chk("midreset_cnt", int'(retire_cnt_o), 0);
    // a write presented across an edge while in reset is lost
    drive(2'b01, 6, 'h5A5A, 0, 6, 0);
    step();
    drive(2'b00, 0, 0, 0, 6, 0);
    rst_n = 1'b1;
    #1;
    chk("write_in_reset_lost", int'(rs_data_o), 0);

    // ALU write
    drive(2'b01, 5, 'hBEEF, 'h1111, 5, 0);
    chk("alu_fwd_data", int'(fwd_data_o), 'hBEEF);
    step();
    drive(2'b00, 0, 0, 0, 5, 0);
    chk("alu_r5", int'(rs_data_o), 'hBEEF);
    chk("alu_cnt", int'(retire_cnt_o), 1);

    // Load write
    drive(2'b11, 2, 'h4321, 'h00A5, 0, 2);
    chk("load_fwd_data", int'(fwd_data_o), 'h00A5);
    chk("load_rt_bypass", int'(rt_data_o), 'h00A5);
    step();
    drive(2'b00, 0, 0, 0, 0, 2);
    chk("load_r2", int'(rt_data_o), 'h00A5);
    chk("load_cnt", int'(retire_cnt_o), 2);

    // Bypass on both ports over an existing value
    drive(2'b01, 4, 'h0001, 0, 0, 0);
    step();
    drive(2'b01, 4, 'h7777, 0, 4, 4);
    chk("byp_rs", int'(rs_data_o), 'h7777);
    chk("byp_rt", int'(rt_data_o), 'h7777);
    step();
    drive(2'b00, 0, 0, 0, 4, 5);
    chk("byp_r4", int'(rs_data_o), 'h7777);
    chk("byp_r5_intact", int'(rt_data_o), 'hBEEF);
    chk("byp_cnt", int'(retire_cnt_o), 4);

    // r0 protection
    drive(2'b01, 0, 'hFFFF, 0, 0, 0);
    chk("r0_fwd_en", int'(fwd_en_o), 0);
    chk("r0_rs", int'(rs_data_o), 0);
    step();
    chk("r0_rs_after", int'(rs_data_o), 0);
    chk("r0_cnt", int'(retire_cnt_o), 4);

    // MemtoReg without regWrite: mux visible, no write
    drive(2'b10, 5, 'h0, 'hAAAA, 5, 0);
    chk("noop_fwd_data", int'(fwd_data_o), 'hAAAA);
    chk("noop_fwd_en", int'(fwd_en_o), 0);
    chk("noop_rs", int'(rs_data_o), 'hBEEF);
    step();
    drive(2'b00, 0, 0, 0, 5, 0);
    chk("noop_r5", int'(rs_data_o), 'hBEEF);
    chk("noop_cnt", int'(retire_cnt_o), 4);

    // Counter saturation: 20 writes to r1
    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 1, 'h100 + i, 0, 1, 7);
      step();
    end
    drive(2'b00, 0, 0, 0, 1, 7);
    chk("sat_cnt", int'(retire_cnt_o), 15);
    chk("sat_r1", int'(rs_data_o), 'h113);
    chk("sat_r7", int'(rt_data_o), 0);
    drive(2'b01, 7, 'hC0DE, 0, 1, 7);
    step();
    drive(2'b00, 0, 0, 0, 1, 7);
    chk("sat_hold_cnt", int'(retire_cnt_o), 15);
    chk("sat_r7_written", int'(rt_data_o), 'hC0DE);

    step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
